// File: rtl/fifo_feed_scheduler.sv
// Drains the per-row FWFT FIFOs into the west edge of the systolic array with diagonal skew.
// Row r is fed r steps after row 0; any empty active FIFO stalls the whole wavefront.
module fifo_feed_scheduler #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 4,
    parameter int LEN    = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    input  logic [ROWS-1:0]        i_empty,
    input  logic [ROWS*DATA_W-1:0] i_data,
    output logic [ROWS-1:0]        o_rd,
    output logic [ROWS*DATA_W-1:0] o_a,
    output logic [ROWS-1:0]        o_a_valid,
    output logic                   o_step,
    output logic                   o_stall,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_dbg_state
);
    localparam int STEPS = LEN + ROWS - 1;
    localparam int T_W   = $clog2(LEN + ROWS);
    localparam logic [T_W-1:0] T_LAST = T_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [T_W-1:0]  t, t_nx;
    logic [ROWS-1:0] active;
    logic            fire;
    logic            stall;

    // Skew window: row r consumes during steps r .. r+LEN-1.
    always_comb begin
        active = '0;
        for (int r = 0; r < ROWS; r++) begin
            active[r] = (state == FEED) && (int'(t) >= r) && (int'(t) <= r + LEN - 1);
        end
    end

    assign fire  = (state == FEED) && ((active & i_empty) == '0);
    assign stall = (state == FEED) && !fire;

    assign o_rd        = fire ? active : '0;
    assign o_busy      = (state != IDLE);
    assign o_dbg_state = state;

    always_comb begin
        state_nx = state;
        t_nx     = t;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = FEED;
                    t_nx     = '0;
                end
            end
            FEED: begin
                if (fire) begin
                    if (t == T_LAST) begin
                        state_nx = DONE;
                    end else begin
                        t_nx = t + T_W'(1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                t_nx     = '0;
            end
            default: begin
                state_nx = IDLE;
                t_nx     = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            t         <= '0;
            o_a       <= '0;
            o_a_valid <= '0;
            o_step    <= 1'b0;
            o_stall   <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nx;
            t         <= t_nx;
            o_step    <= fire;
            o_stall   <= stall;
            o_done    <= fire && (t == T_LAST);
            o_a_valid <= fire ? active : '0;
            // Inactive or stalled rows present zero so the array never sees stale operands.
            for (int r = 0; r < ROWS; r++) begin
                o_a[r*DATA_W +: DATA_W] <= (fire && active[r]) ? i_data[r*DATA_W +: DATA_W] : '0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_feed_scheduler.sv
// Bench for fifo_feed_scheduler: behavioural FWFT FIFO bank around the DUT, a table-driven
// stall-free tile and hand-written stall, restart, reset and back-to-back sequences.
module tb_fifo_feed_scheduler;
    localparam int DATA_W = 32;
    localparam int ROWS   = 4;
    localparam int LEN    = 4;
    localparam int DEPTH  = 8;
    localparam int AW     = ROWS * DATA_W;

    typedef struct {
        logic            start;
        logic [ROWS-1:0] rd;
        logic [ROWS-1:0] valid;
        logic            step;
        logic            busy;
        logic            done;
        logic [AW-1:0]   a;
    } vec_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [ROWS-1:0] i_empty;
    logic [AW-1:0]   i_data;
    logic [ROWS-1:0] o_rd;
    logic [AW-1:0]   o_a;
    logic [ROWS-1:0] o_a_valid;
    logic            o_step;
    logic            o_stall;
    logic            o_busy;
    logic            o_done;
    logic [1:0]      o_dbg_state;

    logic [DATA_W-1:0] fq[ROWS][$];
    int   pop_cnt[ROWS];
    int   cyc;
    int   total;
    int   bad;
    int   done_cnt;
    vec_t tbl[10];

    fifo_feed_scheduler #(.DATA_W(DATA_W), .ROWS(ROWS), .LEN(LEN)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_empty     (i_empty),
        .i_data      (i_data),
        .o_rd        (o_rd),
        .o_a         (o_a),
        .o_a_valid   (o_a_valid),
        .o_step      (o_step),
        .o_stall     (o_stall),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic st, input logic [3:0] rd, input logic [3:0] v,
                                 input logic step, input logic busy, input logic done,
                                 input logic [31:0] a3, input logic [31:0] a2,
                                 input logic [31:0] a1, input logic [31:0] a0);
        vec_t x;
        x.start = st;
        x.rd    = rd;
        x.valid = v;
        x.step  = step;
        x.busy  = busy;
        x.done  = done;
        x.a     = {a3, a2, a1, a0};
        return x;
    endfunction

    function automatic logic [DATA_W-1:0] row_a(input int r);
        return o_a[r*DATA_W +: DATA_W];
    endfunction

    task automatic refresh();
        for (int r = 0; r < ROWS; r++) begin
            i_empty[r] = (fq[r].size() == 0);
            i_data[r*DATA_W +: DATA_W] = i_empty[r] ? 32'hDEAD_BEEF : fq[r][0];
        end
    endtask

    task automatic fifo_push(input int r, input logic [DATA_W-1:0] v);
        chk("fifo_overflow", fq[r].size() >= DEPTH, 0);
        if (fq[r].size() < DEPTH) fq[r].push_back(v);
        refresh();
    endtask

    task automatic preload(input int r, input int n);
        for (int i = 0; i < n; i++) fifo_push(r, DATA_W'(r * 16 + i));
    endtask

    task automatic new_test();
        cyc = 0;
        done_cnt = 0;
        for (int r = 0; r < ROWS; r++) pop_cnt[r] = 0;
    endtask

    task automatic to_mid();
        @(negedge clk);
        if (o_done) done_cnt++;
    endtask

    // Read strobes sampled mid-cycle take effect at the following rising edge.
    task automatic advance();
        logic [ROWS-1:0] rd_s;
        rd_s = o_rd;
        @(posedge clk);
        #1;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_s[r]) begin
                chk("fifo_underflow", fq[r].size() == 0, 0);
                if (fq[r].size() != 0) begin
                    void'(fq[r].pop_front());
                    pop_cnt[r]++;
                end
            end
        end
        refresh();
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic seen;
        total = 0;
        bad   = 0;
        tbl[0] = mkv(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mkv(0, 4'b0001, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        tbl[2] = mkv(0, 4'b0011, 4'b0001, 1, 1, 0, 0, 0, 0, 32'h00);
        tbl[3] = mkv(0, 4'b0111, 4'b0011, 1, 1, 0, 0, 0, 32'h10, 32'h01);
        tbl[4] = mkv(0, 4'b1111, 4'b0111, 1, 1, 0, 0, 32'h20, 32'h11, 32'h02);
        tbl[5] = mkv(0, 4'b1110, 4'b1111, 1, 1, 0, 32'h30, 32'h21, 32'h12, 32'h03);
        tbl[6] = mkv(0, 4'b1100, 4'b1110, 1, 1, 0, 32'h31, 32'h22, 32'h13, 0);
        tbl[7] = mkv(0, 4'b1000, 4'b1100, 1, 1, 0, 32'h32, 32'h23, 0, 0);
        tbl[8] = mkv(0, 4'b0000, 4'b1000, 1, 1, 1, 32'h33, 0, 0, 0);
        tbl[9] = mkv(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

        // Clock/reset
        start = 1'b0;
        rstn  = 1'b1;
        cyc   = 0;
        refresh();
        #1 rstn = 1'b0;
        #2;
        chk("rst_rd", o_rd, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_a", o_a, 0);
        chk("rst_valid", o_a_valid, 0);
        chk("rst_flags", {o_step, o_stall, o_done}, 0);
        chk("rst_state", o_dbg_state, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // A: stall-free tile from the table
        new_test();
        for (int r = 0; r < ROWS; r++) preload(r, LEN);
        for (int c = 0; c < 10; c++) begin
            start = tbl[c].start;
            to_mid();
            chk("a_rd", o_rd, tbl[c].rd);
            chk("a_valid", o_a_valid, tbl[c].valid);
            chk("a_step", o_step, tbl[c].step);
            chk("a_stall", o_stall, 0);
            chk("a_busy", o_busy, tbl[c].busy);
            chk("a_done", o_done, tbl[c].done);
            chk("a_data", o_a, tbl[c].a);
            advance();
        end
        chk("a_fifos_empty", i_empty, 4'hf);

        // B: row 3 short one word, pushed late
        new_test();
        for (int r = 0; r < ROWS - 1; r++) preload(r, LEN);
        preload(3, LEN - 1);
        for (int c = 0; c < 14; c++) begin
            start = (c == 0);
            to_mid();
            if (c >= 7 && c <= 10) chk("b_rd_stalled", o_rd, 0);
            if (c >= 8 && c <= 11) chk("b_stall", o_stall, 1);
            if (c == 11) chk("b_rd_release", o_rd, 4'b1000);
            if (c == 12) begin
                chk("b_a3", row_a(3), 32'h33);
                chk("b_valid", o_a_valid, 4'b1000);
                chk("b_step_done", {o_step, o_done, o_stall}, 3'b110);
            end
            if (c == 13) chk("b_idle", o_busy, 0);
            advance();
            if (c == 10) fifo_push(3, 32'h33);
        end
        chk("b_done_cnt", done_cnt, 1);
        for (int r = 0; r < ROWS; r++) chk("b_pops", pop_cnt[r], LEN);
        chk("b_fifos_empty", i_empty, 4'hf);

        // C: row 0 empty at start
        new_test();
        for (int r = 1; r < ROWS; r++) preload(r, LEN);
        for (int c = 0; c < 6; c++) begin
            start = (c == 0);
            to_mid();
            if (c >= 1) chk("c_rd_none", o_rd, 0);
            if (c >= 2) chk("c_stall", o_stall, 1);
            if (c >= 1) chk("c_busy", o_busy, 1);
            advance();
        end
        fifo_push(0, 32'h00);
        to_mid();
        chk("c_rd_release", o_rd, 4'b0001);
        advance();
        to_mid();
        chk("c_step", {o_step, o_stall}, 2'b10);
        chk("c_valid", o_a_valid, 4'b0001);
        chk("c_rd_wait_row0", o_rd, 0);
        advance();
        for (int i = 1; i < LEN; i++) fifo_push(0, DATA_W'(i));
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            to_mid();
            if (o_done) seen = 1'b1;
            advance();
        end
        chk("c_done_seen", seen, 1);
        chk("c_fifos_empty", i_empty, 4'hf);
        chk("c_pops0", pop_cnt[0], LEN);

        // D: i_start while busy is ignored
        new_test();
        for (int r = 0; r < ROWS; r++) preload(r, LEN);
        for (int c = 0; c < 15; c++) begin
            start = (c == 0 || c == 3);
            to_mid();
            if (c == 8) chk("d_done", o_done, 1);
            if (c >= 9) chk("d_no_second", {o_busy, o_rd}, 0);
            advance();
        end
        chk("d_done_cnt", done_cnt, 1);
        for (int r = 0; r < ROWS; r++) chk("d_pops", pop_cnt[r], LEN);

        // E: asynchronous reset in cycle 4, then restart from leftover words
        new_test();
        for (int r = 0; r < ROWS; r++) preload(r, LEN);
        for (int c = 0; c < 4; c++) begin
            start = (c == 0);
            to_mid();
            advance();
        end
        #1 rstn = 1'b0;
        #1;
        chk("e_rst_rd_busy", {o_rd, o_busy}, 0);
        chk("e_rst_a", o_a, 0);
        chk("e_rst_regs", {o_a_valid, o_step, o_stall, o_done}, 0);
        chk("e_rst_state", o_dbg_state, 0);
        start = 1'b1;
        to_mid();
        advance();
        chk("e_start_in_rst", {o_busy, o_dbg_state}, 0);
        start = 1'b0;
        #1 rstn = 1'b1;
        chk("e_left0", fq[0].size(), 1);
        chk("e_left1", fq[1].size(), 2);
        chk("e_left2", fq[2].size(), 3);
        chk("e_left3", fq[3].size(), 4);
        for (int i = 4; i < 7; i++) fifo_push(0, DATA_W'(i));
        fifo_push(1, 32'h14);
        fifo_push(1, 32'h15);
        fifo_push(2, 32'h24);
        new_test();
        for (int c = 0; c < 10; c++) begin
            start = (c == 0);
            to_mid();
            if (c == 2) chk("e_a0", {o_a_valid[0], row_a(0)}, {1'b1, 32'h03});
            if (c == 3) chk("e_a1", row_a(1), 32'h12);
            if (c == 4) chk("e_a2", row_a(2), 32'h21);
            if (c == 5) chk("e_a3", row_a(3), 32'h30);
            if (c == 8) chk("e_done", o_done, 1);
            if (c == 9) chk("e_idle", o_busy, 0);
            advance();
        end
        chk("e_fifos_empty", i_empty, 4'hf);

        // F: back-to-back tiles, 8th word pushed after the first reads
        new_test();
        for (int r = 0; r < ROWS; r++) preload(r, DEPTH - 1);
        for (int c = 0; c < 23; c++) begin
            start = (c == 0 || c == 9);
            to_mid();
            if (c >= 12 && c <= 15) begin
                chk("f_a1", row_a(1), DATA_W'(32'h14 + c - 12));
                chk("f_v1", o_a_valid[1], 1);
            end
            if (c == 8 || c == 17) chk("f_done", o_done, 1);
            advance();
            if (c == 4) begin
                for (int r = 0; r < ROWS; r++) fifo_push(r, DATA_W'(r * 16 + 7));
            end
        end
        chk("f_done_cnt", done_cnt, 2);
        for (int r = 0; r < ROWS; r++) chk("f_pops", pop_cnt[r], 2 * LEN);
        chk("f_fifos_empty", i_empty, 4'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_feed_scheduler.md
# fifo_feed_scheduler

Sequencer that drains the four per-row input FIFOs (8-deep, 32-bit, first-word-fall-through) into the west edge of the 4x4 systolic array. It applies the diagonal skew, so row r starts r steps after row 0. On i_start it streams LEN words from every row FIFO. If any FIFO it needs is empty, it stalls the whole wavefront. It sits between the FIFO bank and the PE array, and it owns every FIFO read strobe.

## Interface
- DATA_W, 32, word width per row
- ROWS, 4, number of array rows / FIFOs
- LEN, 4, words consumed per row per tile; legal range 1..7 (usable FIFO depth)
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  reset, asynchronous assert, active-low
- i_start  in  1  start a tile; sampled only in IDLE
- i_empty  in  ROWS  per-FIFO o_empty
- i_data  in  ROWS*DATA_W  per-FIFO o_data; row r at bits [r*DATA_W +: DATA_W]
- o_rd  out  ROWS  per-FIFO i_rd; combinational, one pulse per consumed word
- o_a  out  ROWS*DATA_W  registered operand to the array; 0 when the row is not valid
- o_a_valid  out  ROWS  registered, per-row operand valid
- o_step  out  1  registered; high the cycle after a step executed (array advance enable)
- o_stall  out  1  registered; high the cycle after a stalled step
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at tile end

## Operation
- States:
  - IDLE: i_start -> FEED, step counter t <= 0.
  - FEED: runs steps t = 0 .. LEN+ROWS-2.
  - DONE: one cycle, then -> IDLE.
- Row r is active at step t when r <= t <= r+LEN-1. Inactive rows ignore i_empty and get o_rd = 0.
- Step fires when FEED and no active row has i_empty = 1. On a fire:
  - o_rd[r] = 1 for every active row.
  - Next cycle: o_a row r <= i_data row r, o_a_valid[r] <= 1 for active rows; o_a row = 0 and o_a_valid = 0 for inactive rows.
  - o_step <= 1, and t increments.
- Stall (FEED with some active row empty):
  - o_rd = 0, t held.
  - Next cycle: o_a_valid = 0, o_a = 0, o_step = 0, o_stall = 1.
- At a fire with t = LEN+ROWS-2: -> DONE. In DONE, o_done = 1, o_rd = 0, and o_step/o_a reflect the final step.
- i_start is ignored while o_busy = 1.
- The counter t is $clog2(LEN+ROWS) bits wide and never wraps in normal operation.
- This block never touches FIFO pointers. FIFO full/empty are owned by the FIFOs.

## Timing
- Reset (i_rstn low, any time including mid-tile): state IDLE, t = 0, and all registered outputs = 0: o_a, o_a_valid, o_step, o_stall, o_done. o_rd = 0 and o_busy = 0 immediately, since they are combinational from state. A tile interrupted by reset is abandoned. Words already read are lost.
- Cycle numbering: i_start is high in cycle 0 and sampled at the edge ending cycle 0.
- Stall-free tile:
  - FEED occupies cycles 1 .. LEN+ROWS-1.
  - o_rd[r] is high in cycles 1+r .. LEN+r.
  - o_a_valid[r] is high in cycles 2+r .. LEN+1+r.
  - o_done is high in cycle LEN+ROWS.
  - IDLE resumes in cycle LEN+ROWS+1, where a new i_start is accepted.
- Latency: FIFO word to o_a is 1 cycle. Each stall cycle delays all later events by exactly 1 cycle.
- Simultaneous events:
  - i_start together with reset: reset wins.
  - i_empty deasserting in a stall cycle allows a fire in the following cycle. Evaluation is combinational on the current i_empty.

## Test plan
- Reset all FIFOs. Preload row r with words 0xR0..0xR3 (LEN=4). Pulse i_start in cycle 0. Required:
  - o_rd[2] high in cycles 3-6.
  - o_a row 2 = 0x20, 0x21, 0x22, 0x23 in cycles 4-7, with o_a_valid[2] high.
  - o_done in cycle 8, o_busy low in cycle 9, and all FIFOs empty.
- Same preload, but row 3 gets only 3 words; push its 4th word in cycle 10. Required:
  - Stall at step t=6: o_rd = 0 and o_stall = 1 until the push.
  - Fire in the cycle after the push; o_a row 3 = 0x33 one cycle later.
  - o_done follows the final step. No row other than row 3 sees an extra rd.
- Row 0 empty at start. Required: no o_rd asserted and o_stall = 1 each cycle after cycle 1. Pushing 0x00 releases the step.
- Pulse i_start in cycle 3 of a running tile. Required: ignored; the tile ends in cycle 8 unchanged, and no second tile runs.
- Assert i_rstn low in cycle 4 of a tile. Required: all outputs 0 asynchronously and state IDLE. A new i_start after release runs a full 8-cycle tile from the remaining FIFO contents.
- Back-to-back tiles with 8 words per row preloaded (FIFO holds 7, so push the 8th after the first reads; FIFO depth is 8, usable 7). Required: tile 2 o_a row 1 = 0x14..0x17, and o_done pulses exactly twice.
